// File: rtl/multi_er_monitor.sv
// Executable-region proof-of-execution monitor with attestation-ROM / key-region
// access guard. Each ER channel proves an uninterrupted ER_min..ER_max run.
module multi_er_monitor #(
    parameter int          N_ER      = 2,
    parameter logic [15:0] SMEM_BASE = 16'hA000,
    parameter logic [15:0] SMEM_SIZE = 16'h4000,
    parameter logic [15:0] KMEM_BASE = 16'h6A00,
    parameter logic [15:0] KMEM_SIZE = 16'h001F,
    parameter int          RST_HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 puc,
    input  logic [15:0]          pc,
    input  logic                 data_en,
    input  logic                 data_wr,
    input  logic [15:0]          data_addr,
    input  logic                 dma_en,
    input  logic [15:0]          dma_addr,
    input  logic                 irq,
    input  logic [16*N_ER-1:0]   ER_min,
    input  logic [16*N_ER-1:0]   ER_max,
    input  logic [16*N_ER-1:0]   OR_min,
    input  logic [16*N_ER-1:0]   OR_max,
    output logic [N_ER-1:0]      exec,
    output logic                 reset,
    output logic [2:0]           viol_code
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} er_state_t;

    localparam logic [16:0] SMEM_END  = 17'(SMEM_BASE) + 17'(SMEM_SIZE) - 17'd1;
    localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam logic [16:0] KMEM_END  = 17'(KMEM_BASE) + 17'(KMEM_SIZE);
    localparam logic [3:0]  HOLD_INIT = 4'(RST_HOLD);

    function automatic logic in_rng(input logic [15:0] a, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic logic in_smem(input logic [15:0] a);
        return (a >= SMEM_BASE) && (17'(a) <= SMEM_END);
    endfunction

    function automatic logic in_kmem(input logic [15:0] a);
        return (a >= KMEM_BASE) && (17'(a) < KMEM_END);
    endfunction

    logic [15:0] pc_prev;
    logic [3:0]  hold_cnt;

    er_state_t   state_q [N_ER];
    er_state_t   state_d [N_ER];
    logic [N_ER-1:0] load_shadow;

    logic [15:0] live_er_min [N_ER];
    logic [15:0] live_er_max [N_ER];
    logic [15:0] live_or_min [N_ER];
    logic [15:0] live_or_max [N_ER];
    logic [15:0] sh_er_min   [N_ER];
    logic [15:0] sh_er_max   [N_ER];
    logic [15:0] sh_or_min   [N_ER];
    logic [15:0] sh_or_max   [N_ER];

    for (genvar g = 0; g < N_ER; g++) begin : g_chan
        assign live_er_min[g] = ER_min[16*g +: 16];
        assign live_er_max[g] = ER_max[16*g +: 16];
        assign live_or_min[g] = OR_min[16*g +: 16];
        assign live_or_max[g] = OR_max[16*g +: 16];
        assign exec[g]        = (state_q[g] == ST_DONE);
    end

    assign reset = (hold_cnt != 4'd0);

    // Security violation detection; lowest cause code wins.
    logic       v_entry, v_exit, v_irq, v_key, v_dma, viol;
    logic [2:0] viol_cause;

    assign v_entry = in_smem(pc) && !in_smem(pc_prev) && (pc != SMEM_BASE);
    assign v_exit  = in_smem(pc_prev) && !in_smem(pc) && (pc_prev != SMEM_LAST);
    assign v_irq   = irq && in_smem(pc);
    assign v_key   = data_en && in_kmem(data_addr) && !in_smem(pc);
    assign v_dma   = dma_en && (in_kmem(dma_addr) || in_smem(dma_addr));
    assign viol    = v_entry || v_exit || v_irq || v_key || v_dma;

    always_comb begin
        viol_cause = 3'd0;
        if (v_entry)     viol_cause = 3'd1;
        else if (v_exit) viol_cause = 3'd2;
        else if (v_irq)  viol_cause = 3'd3;
        else if (v_key)  viol_cause = 3'd4;
        else if (v_dma)  viol_cause = 3'd5;
    end

    // Per-channel event qualifiers, evaluated against the latched bounds.
    logic            cpu_wr;
    logic [N_ER-1:0] pc_in_er, wr_in_er, wr_in_or, dma_hit, bnd_chg;

    assign cpu_wr = data_en && data_wr;

    always_comb begin
        pc_in_er = '0;
        wr_in_er = '0;
        wr_in_or = '0;
        dma_hit  = '0;
        bnd_chg  = '0;
        for (int i = 0; i < N_ER; i++) begin
            pc_in_er[i] = in_rng(pc, sh_er_min[i], sh_er_max[i]);
            wr_in_er[i] = cpu_wr && in_rng(data_addr, sh_er_min[i], sh_er_max[i]);
            wr_in_or[i] = cpu_wr && in_rng(data_addr, sh_or_min[i], sh_or_max[i]);
            dma_hit[i]  = dma_en && (in_rng(dma_addr, sh_er_min[i], sh_er_max[i]) ||
                                     in_rng(dma_addr, sh_or_min[i], sh_or_max[i]));
            bnd_chg[i]  = (live_er_min[i] != sh_er_min[i]) || (live_er_max[i] != sh_er_max[i]) ||
                          (live_or_min[i] != sh_or_min[i]) || (live_or_max[i] != sh_or_max[i]);
        end
    end

    always_comb begin
        load_shadow = '0;
        for (int i = 0; i < N_ER; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (pc == live_er_min[i]) begin
                        state_d[i]     = ST_RUN;
                        load_shadow[i] = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (irq || dma_hit[i] || wr_in_er[i] || bnd_chg[i] ||
                        (cpu_wr && pc_in_er[i] && !in_rng(data_addr, sh_or_min[i], sh_or_max[i])) ||
                        (!pc_in_er[i] && (pc_prev != sh_er_max[i])))
                        state_d[i] = ST_IDLE;
                    else if ((pc_prev == sh_er_max[i]) && !pc_in_er[i])
                        state_d[i] = ST_DONE;
                end
                ST_DONE: begin
                    if (wr_in_er[i] || wr_in_or[i] || dma_hit[i] || bnd_chg[i] ||
                        (pc_in_er[i] && (pc != sh_er_min[i]))) begin
                        state_d[i] = ST_IDLE;
                    end else if (pc == sh_er_min[i]) begin
                        state_d[i]     = ST_RUN;
                        load_shadow[i] = 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            // A violation or an active reset request overrides all channel activity.
            if (viol || reset) begin
                state_d[i]     = ST_IDLE;
                load_shadow[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            pc_prev   <= 16'h0000;
            hold_cnt  <= 4'd0;
            viol_code <= 3'd0;
            for (int i = 0; i < N_ER; i++) begin
                state_q[i]   <= ST_IDLE;
                sh_er_min[i] <= 16'h0000;
                sh_er_max[i] <= 16'h0000;
                sh_or_min[i] <= 16'h0000;
                sh_or_max[i] <= 16'h0000;
            end
        end else begin
            pc_prev <= pc;
            if (viol) begin
                hold_cnt  <= HOLD_INIT;
                viol_code <= viol_cause;
            end else if (hold_cnt != 4'd0) begin
                hold_cnt  <= hold_cnt - 4'd1;
            end
            for (int i = 0; i < N_ER; i++) begin
                state_q[i] <= state_d[i];
                if (load_shadow[i]) begin
                    sh_er_min[i] <= live_er_min[i];
                    sh_er_max[i] <= live_er_max[i];
                    sh_or_min[i] <= live_or_min[i];
                    sh_or_max[i] <= live_or_max[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_er_monitor.sv
// Directed bench for multi_er_monitor: ER proof runs, aborts, clears and
// security-violation reset requests with hand-computed expectations.
module tb_multi_er_monitor;

    logic        clk = 1'b0;
    logic        puc;
    logic [15:0] pc;
    logic        data_en, data_wr;
    logic [15:0] data_addr;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic        irq;
    logic [31:0] ER_min, ER_max, OR_min, OR_max;
    logic [1:0]  exec;
    logic        reset;
    logic [2:0]  viol_code;

    int n_tests = 0;
    int n_fail  = 0;

    // SMEM shrunk to A000..AFFF so the C000 exit address lies outside it.
    multi_er_monitor #(
        .N_ER(2),
        .SMEM_BASE(16'hA000),
        .SMEM_SIZE(16'h1000),
        .KMEM_BASE(16'h6A00),
        .KMEM_SIZE(16'h001F),
        .RST_HOLD(2)
    ) dut (
        .clk(clk), .puc(puc), .pc(pc),
        .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
        .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
        .ER_min(ER_min), .ER_max(ER_max), .OR_min(OR_min), .OR_max(OR_max),
        .exec(exec), .reset(reset), .viol_code(viol_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic walk(input int lo, input int hi, input int irq_at, input bit wr);
        for (int a = lo; a <= hi; a += 2) begin
            pc        = 16'(a);
            irq       = (a == irq_at);
            data_en   = wr && ((a % 32) == 16);
            data_wr   = data_en;
            data_addr = 16'hF002;
            tick();
        end
        irq     = 1'b0;
        data_en = 1'b0;
        data_wr = 1'b0;
    endtask

    initial begin
        puc = 1'b1; pc = 16'h0000; irq = 1'b0;
        data_en = 1'b0; data_wr = 1'b0; data_addr = 16'h0000;
        dma_en = 1'b0; dma_addr = 16'h0000;
        ER_min = {16'h8000, 16'hE000};
        ER_max = {16'h8010, 16'hE100};
        OR_min = {16'h9000, 16'hF000};
        OR_max = {16'h9004, 16'hF004};
        tick(); tick();
        check("rst_exec", 16'(exec), 16'h0);
        check("rst_reset", 16'(reset), 16'h0);
        check("rst_code", 16'(viol_code), 16'h0);
        puc = 1'b0; pc = 16'h4000; tick();

        // Channel 1 proof run
        walk(32'h8000, 32'h8010, -1, 1'b0);
        check("ch1_before_exit", 16'(exec), 16'h0);
        pc = 16'h4000; tick();
        check("ch1_done", 16'(exec), 16'h2);

        // Channel 0 proof run with writes into its OR
        walk(32'hE000, 32'hE100, -1, 1'b1);
        check("ch0_before_exit", 16'(exec), 16'h2);
        pc = 16'hC000; tick();
        check("ch0_done", 16'(exec), 16'h3);

        // DMA into OR0 clears channel 0 only
        dma_en = 1'b1; dma_addr = 16'hF001; tick();
        dma_en = 1'b0;
        check("dma_clear", 16'(exec), 16'h2);

        // New ER_max: old-length run aborts, new-length run completes
        ER_max = {16'h8010, 16'hE102};
        walk(32'hE000, 32'hE100, -1, 1'b1);
        pc = 16'hC000; tick();
        check("short_run", 16'(exec), 16'h2);
        walk(32'hE000, 32'hE102, -1, 1'b1);
        pc = 16'hC000; tick();
        check("new_bound_run", 16'(exec), 16'h3);

        // Re-execution drops exec; irq mid-run aborts channel 0 only
        pc = 16'hE000; tick();
        check("reexec_fall", 16'(exec), 16'h2);
        walk(32'hE002, 32'hE102, 32'hE050, 1'b1);
        pc = 16'hC000; tick();
        check("irq_abort", 16'(exec), 16'h2);

        // Jump into the middle of ER0 never starts a run
        walk(32'hE010, 32'hE102, -1, 1'b0);
        pc = 16'hC000; tick();
        check("mid_entry", 16'(exec), 16'h2);

        // Illegal SMEM entry
        pc = 16'h4000; tick();
        pc = 16'hA010; tick();
        check("entry_reset", 16'(reset), 16'h1);
        check("entry_code", 16'(viol_code), 16'h1);
        check("entry_exec", 16'(exec), 16'h0);
        pc = 16'hA012; tick();
        check("entry_hold2", 16'(reset), 16'h1);
        tick();
        check("entry_release", 16'(reset), 16'h0);

        // Second violation during hold extends it
        puc = 1'b1; pc = 16'h4000; tick();
        puc = 1'b0; tick();
        pc = 16'hA010; tick();
        check("ext_first", 16'(reset), 16'h1);
        pc = 16'hA012; dma_en = 1'b1; dma_addr = 16'h6A04; tick();
        dma_en = 1'b0;
        check("ext_reset", 16'(reset), 16'h1);
        check("ext_code", 16'(viol_code), 16'h5);
        tick();
        check("ext_hold", 16'(reset), 16'h1);
        tick();
        check("ext_release", 16'(reset), 16'h0);
        check("ext_sticky", 16'(viol_code), 16'h5);

        // Exit from SMEM not at its last word
        pc = 16'h4000; tick();
        check("exit_code", 16'(viol_code), 16'h2);
        check("exit_reset", 16'(reset), 16'h1);
        tick(); tick();

        // Key read from outside SMEM
        data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h6A04; tick();
        data_en = 1'b0;
        check("key_code", 16'(viol_code), 16'h4);
        tick(); tick();
        check("key_release", 16'(reset), 16'h0);

        // Legal SMEM entry and exit raise nothing
        pc = 16'hA000; tick();
        check("legal_entry", 16'(reset), 16'h0);
        pc = 16'hAFFE; tick();
        pc = 16'h4000; tick();
        check("legal_exit", 16'(reset), 16'h0);
        check("legal_code", 16'(viol_code), 16'h4);

        // Simultaneous bad entry and irq: code 1 wins over code 3
        pc = 16'hA010; irq = 1'b1; tick();
        irq = 1'b0;
        check("simul_code", 16'(viol_code), 16'h1);

        // puc in the middle of a hold
        pc = 16'h0000; puc = 1'b1; tick();
        check("puc_hold_reset", 16'(reset), 16'h0);
        check("puc_hold_code", 16'(viol_code), 16'h0);
        puc = 1'b0; pc = 16'hC000; tick();

        // puc in the middle of a run, then a clean run
        walk(32'hE000, 32'hE07E, -1, 1'b1);
        pc = 16'hE080; puc = 1'b1; tick();
        check("puc_run_exec", 16'(exec), 16'h0);
        check("puc_run_reset", 16'(reset), 16'h0);
        check("puc_run_code", 16'(viol_code), 16'h0);
        puc = 1'b0; pc = 16'hC000; tick();
        walk(32'hE000, 32'hE102, -1, 1'b1);
        pc = 16'hC000; tick();
        check("post_puc_run", 16'(exec), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_er_monitor.md
MULTI_ER_MONITOR -- requirements
Module: multi_er_monitor

Interface
REQ-001 Parameter N_ER, default 2: number of independent executable-region (ER) channels, legal 1..4.
REQ-002 Parameter SMEM_BASE, default 16'hA000: entry point of the attestation ROM.
REQ-003 Parameter SMEM_SIZE, default 16'h4000: attestation ROM size in bytes.
REQ-004 Parameter KMEM_BASE, default 16'h6A00; KMEM_SIZE, default 16'h001F: key region.
REQ-005 Parameter RST_HOLD, default 2: cycles the reset output is held high per violation, legal 1..15.
REQ-006 clk  in  1  single system clock; all state changes on rising edge.
REQ-007 puc  in  1  synchronous active-high reset.
REQ-008 pc  in  16  current CPU program counter.
REQ-009 data_en, data_wr  in  1 each  CPU data access strobe and write qualifier.
REQ-010 data_addr  in  16  CPU data address.
REQ-011 dma_en  in  1; dma_addr  in  16  DMA access strobe and address.
REQ-012 irq  in  1  interrupt being taken this cycle.
REQ-013 ER_min, ER_max, OR_min, OR_max  in  16*N_ER each  channel i in bits [16i+15:16i]; bounds inclusive.
REQ-014 exec  out  N_ER  per-channel proof-of-execution flag.
REQ-015 reset  out  1  MCU reset request on security violation.
REQ-016 viol_code  out  3  sticky cause of last reset request: 0 none, 1 illegal SMEM entry, 2 SMEM exit, 3 irq in SMEM, 4 CPU key read outside SMEM, 5 DMA to KMEM/SMEM.

Function
REQ-017 Module registers pc_prev each cycle; "in_X(a)" means X_min <= a <= X_max.
REQ-018 Each channel runs a registered FSM with states IDLE, RUN, DONE; exec[i] = (state_i == DONE).
REQ-019 IDLE -> RUN when pc == ER_min[i]; latches ER_min/ER_max/OR_min/OR_max[i] into shadow registers.
REQ-020 RUN -> IDLE (abort) on any of: irq; dma_en with dma_addr in ER or OR; CPU write inside ER; CPU write outside OR while in_ER(pc); pc outside ER while pc_prev != ER_max; live bounds != shadow bounds.
REQ-021 RUN -> DONE when pc_prev == ER_max[i], pc outside ER, and no abort condition holds that cycle; exec[i] rises on the following edge.
REQ-022 DONE -> IDLE on: CPU write into ER or OR; dma_en into ER or OR; live bounds != shadow bounds; pc in ER and pc != ER_min.
REQ-023 DONE -> RUN when pc == ER_min[i] (re-execution); exec[i] falls on that edge.
REQ-024 Jump into ER at any address other than ER_min never leaves IDLE.
REQ-025 Channels are fully independent; overlapping ERs allowed, each evaluated on its own bounds.
REQ-026 Violation detect: pc enters SMEM from outside at address != SMEM_BASE; pc leaves SMEM from an address other than its last word (SMEM_BASE+SMEM_SIZE-2); irq while pc in SMEM; CPU data access to KMEM while pc outside SMEM; dma_en into KMEM or SMEM.
REQ-027 On violation: reset = 1 from next edge for RST_HOLD cycles via 4-bit down-counter; viol_code loaded with cause (lowest code wins on simultaneous causes).
REQ-028 Violation during hold reloads counter to RST_HOLD and updates viol_code.
REQ-029 While reset == 1 all channels forced to IDLE (exec = 0).
REQ-030 Priority per cycle: puc > security violation > channel abort/clear > channel start/complete.

Reset
REQ-031 puc sampled on clk: all channels IDLE, exec = 0, reset = 0, hold counter = 0, viol_code = 0, pc_prev = RESET vector 16'h0000, shadow bounds = 0.
REQ-032 puc mid-RUN or mid-hold aborts immediately; no exec or reset pulse survives puc.

Verification
REQ-033 ER0=E000..E100, OR0=F000..F004; pc E000 -> E002 .. E100 -> C000, writes only to F002 -> exec[0]=1 one edge after pc=C000.
REQ-034 Same run with irq=1 at pc=E050 -> channel 0 returns IDLE, exec[0] stays 0; channel 1 unaffected.
REQ-035 exec[0]=1, then DMA write to F001 -> exec[0]=0 next edge; then change ER_max to E102 with fresh run -> completes only on new bounds.
REQ-036 pc jumps 0x4000 -> A010 -> reset=1 for exactly RST_HOLD=2 cycles, viol_code=1, exec all 0.
REQ-037 Second violation (dma to 6A04) during hold cycle 1 -> reset held 2 further cycles, viol_code=5.
REQ-038 puc asserted during RUN at pc=E080 -> all outputs at reset values next edge; subsequent clean run still yields exec[0]=1.
